// File: rtl/rifl_link_ctrl.sv
// Link bring-up / recovery sequencer for a multi-lane RIFL link on init_clk.
// Optional error monitor: define RIFL_LINK_CTRL_ERR_MON_EN to build it in.
module rifl_link_ctrl #(
  parameter int N_CHANNEL        = 1,
  parameter int GT_RST_CYCLES    = 1024,
  parameter int FRAME_RST_CYCLES = 256,
  parameter int ALIGN_TIMEOUT    = 2**20,
  parameter int LINK_TIMEOUT     = 2**22,
  parameter int DOWN_FILTER      = 16,
  parameter int MAX_RETRIES      = 8,
  parameter int ERR_WINDOW       = 65536,
  parameter int ERR_THRESHOLD    = 16
) (
  input  logic                 init_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CHANNEL-1:0] rx_aligned,
  input  logic [N_CHANNEL-1:0] link_up,
  input  logic [N_CHANNEL-1:0] rx_error,
  output logic                 gt_rst,
  output logic                 frame_rst,
  output logic                 link_ready,
  output logic                 link_fail,
  output logic [2:0]           ctrl_state,
  output logic [7:0]           retry_cnt,
  output logic                 err_retrain
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GT_RST     = 3'd1,
    ST_FRAME_RST  = 3'd2,
    ST_WAIT_ALIGN = 3'd3,
    ST_WAIT_LINK  = 3'd4,
    ST_UP         = 3'd5,
    ST_RETRY      = 3'd6,
    ST_FAIL       = 3'd7
  } state_t;

  localparam int TW_GT = $clog2(GT_RST_CYCLES + 1);
  localparam int TW_FR = $clog2(FRAME_RST_CYCLES + 1);
  localparam int TW_AL = $clog2(ALIGN_TIMEOUT + 1);
  localparam int TW_LK = $clog2(LINK_TIMEOUT + 1);
  localparam int TW_A  = (TW_GT > TW_FR) ? TW_GT : TW_FR;
  localparam int TW_B  = (TW_AL > TW_LK) ? TW_AL : TW_LK;
  localparam int TW    = (TW_A > TW_B) ? TW_A : TW_B;
  localparam int DW    = $clog2(DOWN_FILTER + 1);

  localparam logic [TW-1:0] GT_TC = TW'(GT_RST_CYCLES);
  localparam logic [TW-1:0] FR_TC = TW'(FRAME_RST_CYCLES);
  localparam logic [TW-1:0] AL_TC = TW'(ALIGN_TIMEOUT);
  localparam logic [TW-1:0] LK_TC = TW'(LINK_TIMEOUT);
  localparam logic [DW-1:0] DN_TC = DW'(DOWN_FILTER);

  state_t r_state;
  state_t w_state_nxt;

  logic [N_CHANNEL-1:0] r_aln_s1, r_aln_s2;
  logic [N_CHANNEL-1:0] r_lnk_s1, r_lnk_s2;
  logic                 w_all_aligned;
  logic                 w_all_up;

  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_inc;
  logic [DW-1:0] r_dn;
  logic [DW-1:0] w_dn_inc;
  logic          w_dn_trip;
  logic          w_err_trip;

  logic [7:0] r_retry;
  logic       r_gt_rst;
  logic       r_frame_rst;
  logic       r_ready;
  logic       r_fail;
  logic       r_err_retrain;

  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      r_aln_s1 <= '0;
      r_aln_s2 <= '0;
      r_lnk_s1 <= '0;
      r_lnk_s2 <= '0;
    end else begin
      r_aln_s1 <= rx_aligned;
      r_aln_s2 <= r_aln_s1;
      r_lnk_s1 <= link_up;
      r_lnk_s2 <= r_lnk_s1;
    end
  end

  assign w_all_aligned = &r_aln_s2;
  assign w_all_up      = &r_lnk_s2;
  assign w_tmr_inc     = r_tmr + TW'(1);
  assign w_dn_inc      = r_dn + DW'(1);
  assign w_dn_trip     = (r_state == ST_UP) && !w_all_up && (w_dn_inc >= DN_TC);

`ifdef RIFL_LINK_CTRL_ERR_MON_EN
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESHOLD + 2);
  localparam logic [WW-1:0] WIN_LAST = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] ERR_TH   = EW'(ERR_THRESHOLD);

  logic [N_CHANNEL-1:0] r_err_s1, r_err_s2;
  logic [WW-1:0]        r_win;
  logic [EW-1:0]        r_ecnt;
  logic [EW-1:0]        w_ecnt_nxt;
  logic                 w_err_any;

  assign w_err_any  = |r_err_s2;
  assign w_ecnt_nxt = r_ecnt + EW'(w_err_any);
  assign w_err_trip = (r_state == ST_UP) && (w_ecnt_nxt > ERR_TH);

  // Window is held at zero outside UP so it restarts on every UP entry;
  // the count cannot overflow because a trip always leaves UP.
  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      r_err_s1 <= '0;
      r_err_s2 <= '0;
      r_win    <= '0;
      r_ecnt   <= '0;
    end else begin
      r_err_s1 <= rx_error;
      r_err_s2 <= r_err_s1;
      if (r_state != ST_UP || r_win == WIN_LAST) begin
        r_win  <= '0;
        r_ecnt <= '0;
      end else begin
        r_win  <= r_win + WW'(1);
        r_ecnt <= w_ecnt_nxt;
      end
    end
  end
`else
  logic w_unused_err;
  assign w_unused_err = (^rx_error) ^ (ERR_WINDOW > 0) ^ (ERR_THRESHOLD > 0);
  assign w_err_trip   = 1'b0;
`endif

  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       w_state_nxt = ST_GT_RST;
        ST_GT_RST:     if (w_tmr_inc >= GT_TC) w_state_nxt = ST_FRAME_RST;
        ST_FRAME_RST:  if (w_tmr_inc >= FR_TC) w_state_nxt = ST_WAIT_ALIGN;
        ST_WAIT_ALIGN: begin
          if (w_all_aligned)           w_state_nxt = ST_WAIT_LINK;
          else if (w_tmr_inc >= AL_TC) w_state_nxt = ST_RETRY;
        end
        ST_WAIT_LINK: begin
          if (w_all_up)                w_state_nxt = ST_UP;
          else if (w_tmr_inc >= LK_TC) w_state_nxt = ST_RETRY;
        end
        ST_UP:         if (w_dn_trip || w_err_trip) w_state_nxt = ST_RETRY;
        ST_RETRY: begin
          if (MAX_RETRIES != 0 && 32'(r_retry) >= MAX_RETRIES) w_state_nxt = ST_FAIL;
          else                                                  w_state_nxt = ST_GT_RST;
        end
        ST_FAIL:       w_state_nxt = ST_FAIL;
        default:       w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shared phase timer; cleared on any state change, saturates instead of wrapping.
  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
      r_dn  <= '0;
    end else begin
      if (w_state_nxt != r_state) r_tmr <= '0;
      else if (r_tmr != '1)       r_tmr <= w_tmr_inc;

      if (w_state_nxt != r_state || r_state != ST_UP || w_all_up) r_dn <= '0;
      else if (r_dn != '1)                                         r_dn <= w_dn_inc;
    end
  end

  // retry_cnt already holds the new value during the RETRY cycle.
  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      r_retry <= '0;
    end else if (w_state_nxt == ST_IDLE ||
                 (w_state_nxt == ST_UP && r_state == ST_WAIT_LINK)) begin
      r_retry <= '0;
    end else if (w_state_nxt == ST_RETRY && r_state != ST_RETRY && r_retry != 8'hFF) begin
      r_retry <= r_retry + 8'd1;
    end
  end

  // Resets are also held through RETRY so the core sees one continuous reset into GT_RST.
  always_ff @(posedge init_clk or posedge rst) begin
    if (rst) begin
      r_gt_rst      <= 1'b1;
      r_frame_rst   <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
      r_err_retrain <= 1'b0;
    end else begin
      r_gt_rst      <= (w_state_nxt inside {ST_IDLE, ST_GT_RST, ST_RETRY, ST_FAIL});
      r_frame_rst   <= (w_state_nxt inside {ST_IDLE, ST_GT_RST, ST_FRAME_RST, ST_RETRY, ST_FAIL});
      r_ready       <= (w_state_nxt == ST_UP);
      r_fail        <= (w_state_nxt == ST_FAIL);
      r_err_retrain <= (w_state_nxt == ST_RETRY) && w_err_trip;
    end
  end

  assign gt_rst      = r_gt_rst;
  assign frame_rst   = r_frame_rst;
  assign link_ready  = r_ready;
  assign link_fail   = r_fail;
  assign ctrl_state  = r_state;
  assign retry_cnt   = r_retry;
  assign err_retrain = r_err_retrain;

endmodule
